// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM read arbiter.
// Arbitration mode is selected by RAM_ARB_ROUND_ROBIN_EN (see arb2_pick).
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb2_pick.sv
// Combinational 2-way pick over eligible requests.
// RAM_ARB_ROUND_ROBIN_EN defined: ties go to the client that was not granted last;
// otherwise client 0 always wins a tie.
module arb2_pick
    import ram_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic [1:0] elig,
    output logic       gnt_vld,
    output logic       winner
);

    logic req0_e;
    logic req1_e;

    assign req0_e  = req0 & elig[0];
    assign req1_e  = req1 & elig[1];
    assign gnt_vld = req0_e | req1_e;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = CLIENT0;
        if (req0_e && req1_e) begin
            winner = (last == CLIENT0) ? CLIENT1 : CLIENT0;
        end else if (req1_e) begin
            winner = CLIENT1;
        end
    end
`else
    // Fixed priority has no use for the history bit.
    logic last_unused;
    assign last_unused = last;

    always_comb begin
        winner = CLIENT0;
        if (!req0_e && req1_e) begin
            winner = CLIENT1;
        end
    end
`endif

endmodule

// File: rtl/ram_read_arbiter.sv
// Two-requester read arbiter/sequencer for a 16-entry async-read RAM.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin ties; default is fixed priority (client 0).
//
// state | meaning
// IDLE  | no access in flight, waiting for a request
// READ  | ram_addr driven for owner, RAM data captured at end of cycle
// RESP  | ack[owner] high; the other client may be granted back-to-back
module ram_read_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              last;
    logic [1:0]        elig;
    logic              gnt_vld;
    logic              winner;

    // The owner's request is masked in RESP so only the other client can chain.
    always_comb begin
        elig = 2'b00;
        if (state_q == IDLE) begin
            elig = 2'b11;
        end else if (state_q == RESP) begin
            elig = (owner_q == CLIENT0) ? 2'b10 : 2'b01;
        end
    end

    arb2_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .last    (last),
        .elig    (elig),
        .gnt_vld (gnt_vld),
        .winner  (winner)
    );

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (gnt_vld) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CLIENT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last = last_q;
`else
    assign last = CLIENT1;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ram_addr_d = ram_addr_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d    = winner;
                    ram_addr_d = (winner == CLIENT1) ? addr1 : addr0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (owner_q == CLIENT1) begin
                    rdata1_d = ram_data;
                end else begin
                    rdata0_d = ram_data;
                end
                state_d = RESP;
            end
            RESP: begin
                if (gnt_vld) begin
                    owner_d    = winner;
                    ram_addr_d = (winner == CLIENT1) ? addr1 : addr0;
                    state_d    = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= CLIENT0;
            ram_addr_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ram_addr_q <= ram_addr_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ack0     = (state_q == RESP) && (owner_q == CLIENT0);
    assign ack1     = (state_q == RESP) && (owner_q == CLIENT1);
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_addr = ram_addr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Scoreboard bench for ram_read_arbiter; expectations follow RAM_ARB_ROUND_ROBIN_EN.
// RAM model: entry k holds 0x1000_0000 + k.
module tb_ram_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [3:0]  addr0, addr1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  ram_addr;
    logic [31:0] ram_data;
    logic        busy;

    always #5 clk = ~clk;

    assign ram_data = 32'h1000_0000 + {28'h0, ram_addr};

    ram_read_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy)
    );

    typedef struct packed {
        logic        c;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic c, input logic [3:0] a);
        exp_t e;
        e.c = c;
        e.d = 32'h1000_0000 + {28'h0, a};
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ack0 || ack1)) begin
            chk("ack_exclusive", {31'h0, ack0 && ack1}, 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_client", {31'h0, ack1}, {31'h0, e.c});
                chk("rdata", ack1 ? rdata1 : rdata0, e.d);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that raised ack.
    task automatic do_read(input logic c, input logic [3:0] a);
        logic got;
        got = 1'b0;
        if (c) begin addr1 = a; req1 = 1'b1; end
        else   begin addr0 = a; req0 = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            got = c ? ack1 : ack0;
        end
        chk("ack_timeout", {31'h0, got}, 32'h1);
        if (c) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addr0 = '0;
        addr1 = '0;
        do_reset();

        chk("rst_ram_addr", {28'h0, ram_addr}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ack", {30'h0, ack1, ack0}, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);

        // Single client 0 access with cycle-exact timing.
        sb.push_back(mk(1'b0, 4'd5));
        addr0 = 4'd5;
        req0  = 1'b1;
        @(posedge clk); #1;
        chk("t1_busy_read", {31'h0, busy}, 32'h1);
        chk("t1_ram_addr", {28'h0, ram_addr}, 32'h5);
        chk("t1_ack_early", {31'h0, ack0}, 32'h0);
        @(posedge clk); #1;
        chk("t1_ack0", {31'h0, ack0}, 32'h1);
        chk("t1_rdata0", rdata0, 32'h1000_0005);
        chk("t1_busy_resp", {31'h0, busy}, 32'h1);
        chk("t1_ack1", {31'h0, ack1}, 32'h0);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("t1_idle", {31'h0, busy}, 32'h0);
        chk("t1_ack_done", {30'h0, ack1, ack0}, 32'h0);

        // Simultaneous requests after reset: client 0 first, back-to-back to client 1.
        do_reset();
        sb.push_back(mk(1'b0, 4'd3));
        sb.push_back(mk(1'b1, 4'd9));
        fork
            do_read(1'b0, 4'd3);
            do_read(1'b1, 4'd9);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                chk("t2_no_idle", {31'h0, busy}, 32'h1);
            end
        join
        @(posedge clk); #1;

        // Tie in IDLE right after client 0 was granted.
        do_reset();
        sb.push_back(mk(1'b0, 4'd4));
        do_read(1'b0, 4'd4);
        @(posedge clk); #1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        sb.push_back(mk(1'b1, 4'd8));
        sb.push_back(mk(1'b0, 4'd6));
`else
        sb.push_back(mk(1'b0, 4'd6));
        sb.push_back(mk(1'b1, 4'd8));
`endif
        fork
            do_read(1'b0, 4'd6);
            do_read(1'b1, 4'd8);
        join
        @(posedge clk); #1;

        // Continuous contention: each client re-requests one cycle after its ack.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(1'b0, 4'(2 * i)));
            sb.push_back(mk(1'b1, 4'(2 * i + 1)));
        end
        fork
            for (int i = 0; i < 4; i++) begin
                do_read(1'b0, 4'(2 * i));
                @(posedge clk); #1;
            end
            for (int j = 0; j < 4; j++) begin
                do_read(1'b1, 4'(2 * j + 1));
                @(posedge clk); #1;
            end
        join
        @(posedge clk); #1;

        // Reset during READ abandons the access.
        do_reset();
        sb.push_back(mk(1'b0, 4'd2));
        do_read(1'b0, 4'd2);
        @(posedge clk); #1;
        addr0 = 4'd7;
        req0  = 1'b1;
        @(posedge clk); #1;
        chk("t5_in_read", {31'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ack", {30'h0, ack1, ack0}, 32'h0);
        chk("t5_rst_rdata0", rdata0, 32'h0);
        chk("t5_rst_busy", {31'h0, busy}, 32'h0);
        chk("t5_rst_ram_addr", {28'h0, ram_addr}, 32'h0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_idle_after", {31'h0, busy}, 32'h0);
        sb.push_back(mk(1'b0, 4'd7));
        do_read(1'b0, 4'd7);
        @(posedge clk); #1;

        // Address boundaries on client 1.
        sb.push_back(mk(1'b1, 4'd15));
        do_read(1'b1, 4'd15);
        chk("t6_ram_addr_15", {28'h0, ram_addr}, 32'hF);
        @(posedge clk); #1;
        sb.push_back(mk(1'b1, 4'd0));
        do_read(1'b1, 4'd0);
        chk("t6_ram_addr_0", {28'h0, ram_addr}, 32'h0);
        @(posedge clk); #1;
        chk("t6_rdata1_held", rdata1, 32'h1000_0000);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
